// File: rtl/muldiv_unit.sv
// Iterative RISC-V M-extension multiply/divide unit with a start/done handshake.
// Define MULDIV_FAST_MUL_EN to replace the shift-add multiplier with a single-cycle combinational one.
module muldiv_unit #(
    parameter int XLEN = 32
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_start,
    input  logic [2:0]      i_func_3,
    input  logic [XLEN-1:0] i_op_a,
    input  logic [XLEN-1:0] i_op_b,
    input  logic            i_flush,
    output logic            o_ready,
    output logic            o_done,
    output logic [XLEN-1:0] o_result
);

    localparam int CNT_W = $clog2(XLEN);
    localparam logic signed [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE,
        S_MUL,
        S_DIV,
        S_DONE
    } state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [XLEN-1:0]     result_q, result_d;
    logic [1:0]          func_lo_q, func_lo_d;
    logic                neg_q, neg_d;
    logic                neg_rem_q, neg_rem_d;
    logic [XLEN-1:0]     opnd_q, opnd_d;
    logic [2*XLEN-1:0]   work_q, work_d;

    function automatic logic [XLEN-1:0] neg_narrow(input logic en, input logic [XLEN-1:0] v);
        return en ? ({XLEN{1'b0}} - v) : v;
    endfunction

    function automatic logic [2*XLEN-1:0] neg_wide(input logic en, input logic [2*XLEN-1:0] v);
        return en ? ({(2*XLEN){1'b0}} - v) : v;
    endfunction

    function automatic logic [XLEN-1:0] mul_select(input logic hi, input logic neg,
                                                   input logic [2*XLEN-1:0] prod);
        logic [2*XLEN-1:0] p;
        p = neg_wide(neg, prod);
        return hi ? p[2*XLEN-1:XLEN] : p[XLEN-1:0];
    endfunction

    function automatic logic [XLEN-1:0] div_select(input logic rem_sel, input logic neg_quo,
                                                   input logic neg_rem, input logic [2*XLEN-1:0] w);
        return rem_sel ? neg_narrow(neg_rem, w[2*XLEN-1:XLEN]) : neg_narrow(neg_quo, w[XLEN-1:0]);
    endfunction

    // Operand decode: signedness, magnitudes and the no-iteration divide cases
    logic signed [XLEN-1:0] op_a_s, op_b_s;
    logic                   a_signed, b_signed, a_neg, b_neg;
    logic [XLEN-1:0]        a_mag, b_mag;
    logic                   div_by_zero, div_ovf;

    assign op_a_s = i_op_a;
    assign op_b_s = i_op_b;

    always_comb begin
        if (i_func_3[2]) begin
            a_signed = ~i_func_3[0];
            b_signed = ~i_func_3[0];
        end else begin
            a_signed = (i_func_3[1:0] != 2'b11);
            b_signed = ~i_func_3[1];
        end
    end

    assign a_neg       = a_signed & op_a_s[XLEN-1];
    assign b_neg       = b_signed & op_b_s[XLEN-1];
    assign a_mag       = neg_narrow(a_neg, i_op_a);
    assign b_mag       = neg_narrow(b_neg, i_op_b);
    assign div_by_zero = (i_op_b == {XLEN{1'b0}});
    assign div_ovf     = i_func_3[2] & ~i_func_3[0] & (op_a_s == INT_MIN) & (op_b_s == '1);

`ifdef MULDIV_FAST_MUL_EN
    logic [2*XLEN-1:0] fast_prod;
    assign fast_prod = {{XLEN{1'b0}}, a_mag} * {{XLEN{1'b0}}, b_mag};
`endif

    // One iteration step; work_q holds {acc, multiplier} for MUL and {remainder, dividend/quotient} for DIV
    logic [XLEN:0]     mul_sum;
    logic [2*XLEN-1:0] mul_next;
    logic [XLEN:0]     div_shift;
    logic [XLEN-1:0]   div_diff;
    logic              div_fits;
    logic [2*XLEN-1:0] div_next;

    always_comb begin
        mul_sum   = {1'b0, work_q[2*XLEN-1:XLEN]} + (work_q[0] ? {1'b0, opnd_q} : {(XLEN+1){1'b0}});
        mul_next  = {mul_sum, work_q[XLEN-1:1]};
        div_shift = {work_q[2*XLEN-1:XLEN], work_q[XLEN-1]};
        div_fits  = (div_shift >= {1'b0, opnd_q});
        div_diff  = div_shift[XLEN-1:0] - opnd_q;
        if (div_fits) begin
            div_next = {div_diff, work_q[XLEN-2:0], 1'b1};
        end else begin
            div_next = {div_shift[XLEN-1:0], work_q[XLEN-2:0], 1'b0};
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        result_d  = result_q;
        func_lo_d = func_lo_q;
        neg_d     = neg_q;
        neg_rem_d = neg_rem_q;
        opnd_d    = opnd_q;
        work_d    = work_q;

        case (state_q)
            S_IDLE: begin
                if (i_start) begin
                    func_lo_d = i_func_3[1:0];
                    neg_d     = a_neg ^ b_neg;
                    neg_rem_d = a_neg;
                    cnt_d     = '0;
                    if (!i_func_3[2]) begin
`ifdef MULDIV_FAST_MUL_EN
                        result_d = mul_select(|i_func_3[1:0], a_neg ^ b_neg, fast_prod);
                        state_d  = S_DONE;
`else
                        opnd_d  = a_mag;
                        work_d  = {{XLEN{1'b0}}, b_mag};
                        state_d = S_MUL;
`endif
                    end else if (div_by_zero) begin
                        result_d = i_func_3[1] ? i_op_a : {XLEN{1'b1}};
                        state_d  = S_DONE;
                    end else if (div_ovf) begin
                        result_d = i_func_3[1] ? {XLEN{1'b0}} : i_op_a;
                        state_d  = S_DONE;
                    end else begin
                        opnd_d  = b_mag;
                        work_d  = {{XLEN{1'b0}}, a_mag};
                        state_d = S_DIV;
                    end
                end
            end
            S_MUL: begin
                work_d = mul_next;
                cnt_d  = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(XLEN-1)) begin
                    result_d = mul_select(|func_lo_q, neg_q, mul_next);
                    state_d  = S_DONE;
                end
            end
            S_DIV: begin
                work_d = div_next;
                cnt_d  = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(XLEN-1)) begin
                    result_d = div_select(func_lo_q[1], neg_q, neg_rem_q, div_next);
                    state_d  = S_DONE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Flush beats everything in flight, including a start in the same cycle
        if (i_flush) begin
            state_d  = S_IDLE;
            cnt_d    = '0;
            result_d = result_q;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
        end
    end

    always_ff @(posedge i_clk) begin
        func_lo_q <= func_lo_d;
        neg_q     <= neg_d;
        neg_rem_q <= neg_rem_d;
        opnd_q    <= opnd_d;
        work_q    <= work_d;
    end

    assign o_ready  = (state_q == S_IDLE);
    assign o_done   = (state_q == S_DONE);
    assign o_result = result_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed self-checking bench for muldiv_unit (XLEN = 32).
module tb_muldiv_unit;

    localparam int XLEN = 32;
`ifdef MULDIV_FAST_MUL_EN
    localparam int MUL_LAT = 1;
`else
    localparam int MUL_LAT = 33;
`endif
    localparam int DIV_LAT = 33;

    localparam logic [2:0] F_MUL = 3'b000, F_MULH = 3'b001, F_MULHSU = 3'b010, F_MULHU = 3'b011;
    localparam logic [2:0] F_DIV = 3'b100, F_DIVU = 3'b101, F_REM = 3'b110, F_REMU = 3'b111;

    logic            clk = 1'b0;
    logic            rst;
    logic            start;
    logic [2:0]      func_3;
    logic [XLEN-1:0] op_a, op_b;
    logic            flush;
    logic            ready, done;
    logic [XLEN-1:0] result;

    int n_checks = 0;
    int n_errors = 0;

    muldiv_unit #(.XLEN(XLEN)) dut (
        .i_clk    (clk),
        .i_rst    (rst),
        .i_start  (start),
        .i_func_3 (func_3),
        .i_op_a   (op_a),
        .i_op_b   (op_b),
        .i_flush  (flush),
        .o_ready  (ready),
        .o_done   (done),
        .o_result (result)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present a request, let edge E0 accept it; returns positioned in cycle 1
    task automatic start_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        func_3 = f;
        op_a   = a;
        op_b   = b;
        start  = 1'b1;
        tick();
        start  = 1'b0;
        op_a   = 32'hDEAD_BEEF;
        op_b   = 32'h0BAD_F00D;
    endtask

    task automatic wait_done(input int first_cycle, output int lat);
        int cyc;
        cyc = first_cycle;
        while (!done && cyc < 80) begin
            tick();
            cyc++;
        end
        lat = done ? cyc : -1;
    endtask

    task automatic do_op(input string tag, input logic [2:0] f, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp, input int exp_lat);
        int lat;
        start_op(f, a, b);
        check({tag, " ready_low"}, 32'(ready), 32'd0);
        wait_done(1, lat);
        check({tag, " latency"}, 32'(lat), 32'(exp_lat));
        check({tag, " result"}, result, exp);
        tick();
        check({tag, " single_pulse"}, 32'(done), 32'd0);
        check({tag, " ready_back"}, 32'(ready), 32'd1);
    endtask

    initial begin
        int lat;
        int seen;
        logic [31:0] held;

        rst    = 1'b1;
        start  = 1'b0;
        flush  = 1'b0;
        func_3 = 3'b000;
        op_a   = '0;
        op_b   = '0;
        repeat (3) tick();
        check("reset ready", 32'(ready), 32'd1);
        check("reset done", 32'(done), 32'd0);
        check("reset result", result, 32'd0);
        rst = 1'b0;
        tick();

        do_op("MUL 7*-3",        F_MUL,    32'd7,         32'hFFFF_FFFD, 32'hFFFF_FFEB, MUL_LAT);
        do_op("MULH min*min",    F_MULH,   32'h8000_0000, 32'h8000_0000, 32'h4000_0000, MUL_LAT);
        do_op("MULHU max*max",   F_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, MUL_LAT);
        do_op("MULHSU -1*max",   F_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, MUL_LAT);
        do_op("MUL 3*4",         F_MUL,    32'd3,         32'd4,         32'd12,        MUL_LAT);

        do_op("DIV -7/2",        F_DIV,    32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, DIV_LAT);
        do_op("REM -7/2",        F_REM,    32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, DIV_LAT);
        do_op("DIVU 100/7",      F_DIVU,   32'd100,       32'd7,         32'd14,        DIV_LAT);
        do_op("REMU 100/7",      F_REMU,   32'd100,       32'd7,         32'd2,         DIV_LAT);
        do_op("DIV 100/-7",      F_DIV,    32'd100,       32'hFFFF_FFF9, 32'hFFFF_FFF2, DIV_LAT);

        do_op("DIVU 5/0",        F_DIVU,   32'd5,         32'd0,         32'hFFFF_FFFF, 1);
        do_op("REM 5/0",         F_REM,    32'd5,         32'd0,         32'd5,         1);
        do_op("DIV ovf",         F_DIV,    32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
        do_op("REM ovf",         F_REM,    32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         1);

        // Start pulse during a busy divide must be dropped
        start_op(F_DIVU, 32'd100, 32'd7);
        repeat (4) tick();
        func_3 = F_MUL;
        op_a   = 32'd3;
        op_b   = 32'd4;
        start  = 1'b1;
        tick();
        start  = 1'b0;
        wait_done(6, lat);
        check("busy start latency", 32'(lat), 32'(DIV_LAT));
        check("busy start result", result, 32'd14);
        tick();
        check("busy start no second op", 32'(ready), 32'd1);
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            if (done) seen++;
            tick();
        end
        check("busy start no extra done", 32'(seen), 32'd0);

        // Flush at cycle 10 of a divide
        held = result;
        start_op(F_DIV, 32'hFFFF_FFF9, 32'd2);
        repeat (9) tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("flush ready", 32'(ready), 32'd1);
        check("flush done", 32'(done), 32'd0);
        check("flush result held", result, held);
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            if (done) seen++;
            tick();
        end
        check("flush no done", 32'(seen), 32'd0);
        check("flush result still held", result, held);

        // Flush together with start in IDLE
        func_3 = F_DIVU;
        op_a   = 32'd9;
        op_b   = 32'd0;
        start  = 1'b1;
        flush  = 1'b1;
        tick();
        start  = 1'b0;
        flush  = 1'b0;
        check("flush+start ready", 32'(ready), 32'd1);
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            if (done) seen++;
            tick();
        end
        check("flush+start no done", 32'(seen), 32'd0);
        check("flush+start result held", result, held);

        // Reset at cycle 5 of a multiply
        start_op(F_MUL, 32'd5, 32'd6);
        repeat (4) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mid rst ready", 32'(ready), 32'd1);
        check("mid rst done", 32'(done), 32'd0);
        check("mid rst result", result, 32'd0);
        do_op("MUL 3*4 after rst", F_MUL, 32'd3, 32'd4, 32'd12, MUL_LAT);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Iterative RISC-V M-extension execution unit: decodes `func_3` of an OP-type instruction with `func_7 = 0000001` into one of eight multiply/divide operations. It computes the result over multiple cycles using a start/done handshake. It sits beside the single-cycle ALU in the execute stage; the main decoder raises `i_start` and stalls the datapath until `o_done`.

## Interface
Parameters:
- `XLEN`, default 32, operand/result width; ≥ 8, power of two.

Ports:
- `i_clk`  in  1  clock; all state changes on rising edge.
- `i_rst`  in  1  synchronous, active-high reset.
- `i_start`  in  1  request; accepted only when `o_ready = 1`.
- `i_func_3`  in  3  operation: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- `i_op_a`  in  XLEN  rs1 (multiplicand / dividend).
- `i_op_b`  in  XLEN  rs2 (multiplier / divisor).
- `i_flush`  in  1  abort the current operation (pipeline flush/trap).
- `o_ready`  out  1  unit idle, can accept `i_start`.
- `o_done`  out  1  one-cycle pulse; `o_result` valid this cycle.
- `o_result`  out  XLEN  result register; holds its last value until the next `o_done`.

## Operation
- States: IDLE, MUL, DIV, DONE.
- IDLE:
  - `o_ready = 1`.
  - On `i_start`: latch `func_3`, operand magnitudes and result-sign flags.
  - Go to MUL (func_3[2] = 0) or DIV (func_3[2] = 1), except for the special divide cases, which go to DONE.
- Signedness:
  - MUL, MULH, DIV, REM: both operands signed.
  - MULHSU: a signed, b unsigned.
  - MULHU, DIVU, REMU: unsigned.
  - Signed operands are converted to magnitude.
- MUL state:
  - Shift-add over XLEN iterations into a 2·XLEN product; iteration counter 0..XLEN-1.
  - The product is negated if exactly one signed operand is negative.
  - MUL returns bits [XLEN-1:0]; the MULH variants return [2·XLEN-1:XLEN].
- DIV state:
  - Restoring division, XLEN iterations.
  - Quotient is negated if the signed operand signs differ.
  - Remainder takes the sign of the dividend.
- Special divide cases (no iteration):
  - Divisor = 0: quotient = all ones; remainder = `i_op_a`.
  - Signed overflow (a = −2^(XLEN−1), b = −1, DIV/REM only): quotient = a; remainder = 0.
- DONE:
  - `o_result` register loaded on entry.
  - `o_done = 1` for exactly one cycle, then IDLE.
- `i_start` while `o_ready = 0` is ignored; no queuing.
- `i_flush`:
  - In any state: IDLE next cycle, no `o_done`, `o_result` unchanged.
  - In the same cycle as `i_start`, flush wins and the start is dropped.
- `i_rst` has priority over everything; reset mid-operation discards it.

## Timing
- Reset values: `o_ready = 1`, `o_done = 0`, `o_result = 0`, state IDLE, counter 0.
- Start accepted at edge E0.
- Iterative MUL/DIV:
  - In MUL/DIV for XLEN cycles, DONE in the next cycle.
  - `o_done` high in cycle XLEN+1 after E0 (33 for XLEN = 32).
- Special divide cases: `o_done` in cycle 1 after E0.
- `o_ready` drops the cycle after E0 and returns the cycle after `o_done`. Minimum start-to-start spacing: latency + 1.
- Operand inputs need to be stable only at E0.

## Configuration
- `MULDIV_FAST_MUL_EN` defined:
  - Multiplies use a single-cycle combinational XLEN×XLEN multiplier, IDLE→DONE directly.
  - `o_done` in cycle 1 after E0.
- `MULDIV_FAST_MUL_EN` undefined:
  - Iterative shift-add; latency XLEN+1.
- Divide behaviour is identical either way.

## Test plan
- MUL a = 7, b = 0xFFFFFFFD → `o_result` 0xFFFFFFEB; `o_done` at cycle 33 (cycle 1 with `MULDIV_FAST_MUL_EN`); single pulse.
- High multiplies:
  - MULH 0x80000000 × 0x80000000 → 0x40000000.
  - MULHU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFE.
  - MULHSU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFF.
- Divides, each with `o_done` at cycle 33:
  - DIV −7 / 2 → 0xFFFFFFFD.
  - REM −7 / 2 → 0xFFFFFFFF.
  - DIVU 100 / 7 → 14.
  - REMU 100 / 7 → 2.
- Special cases, each with `o_done` at cycle 1:
  - DIVU 5 / 0 → 0xFFFFFFFF.
  - REM 5 / 0 → 5.
  - DIV 0x80000000 / 0xFFFFFFFF → 0x80000000.
  - REM of the same operands → 0.
- Handshake:
  - `i_start` pulsed during a DIV is ignored.
  - `i_flush` at cycle 10 of a DIV → no `o_done`, `o_ready = 1` next cycle, `o_result` unchanged.
  - `i_flush` together with `i_start` in IDLE → nothing starts.
- `i_rst` asserted at cycle 5 of a MUL → next cycle `o_ready = 1`, `o_done = 0`, `o_result = 0`; a following MUL 3 × 4 returns 12.
